// File: rtl/i2c_slave_regs_pkg.sv
// Shared constants for the I2C target: register addresses, fixed register
// contents and protocol FSM state encodings.
package i2c_slave_regs_pkg;

  // Register addresses
  localparam logic [7:0] AddrDeviceId   = 8'h00;
  localparam logic [7:0] AddrVersionMaj = 8'h01;
  localparam logic [7:0] AddrVersionMin = 8'h02;
  localparam logic [7:0] AddrScratch0   = 8'h05;
  localparam logic [7:0] AddrScratch1   = 8'h06;
  localparam logic [7:0] AddrLinkCaps   = 8'h10;
  localparam logic [7:0] AddrLinkStatus = 8'h11;
  localparam logic [7:0] AddrSpiRx      = 8'h12;
  localparam logic [7:0] AddrLedOut     = 8'h20;
  localparam logic [7:0] AddrSwIn       = 8'h22;

  // Fixed register contents
  localparam logic [7:0] DeviceId   = 8'hA7;
  localparam logic [7:0] VersionMaj = 8'h01;
  localparam logic [7:0] VersionMin = 8'h00;
  localparam logic [7:0] LinkCaps   = 8'h95;

  // Protocol FSM states
  typedef logic [2:0] state_t;
  localparam state_t StIdle     = 3'd0;
  localparam state_t StAddr     = 3'd1;
  localparam state_t StAckAddr  = 3'd2;
  localparam state_t StWrByte   = 3'd3;
  localparam state_t StAckWr    = 3'd4;
  localparam state_t StRdByte   = 3'd5;
  localparam state_t StRdAck    = 3'd6;
  localparam state_t StWaitStop = 3'd7;

endpackage

// File: rtl/i2c_reg_map.sv
// Register storage and read mux behind the I2C protocol FSM.
module i2c_reg_map
  import i2c_slave_regs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic       wr_i,
  input  logic       rd_i,
  output logic [7:0] rdata_o,
  output logic [7:0] led_o,
  input  logic [7:0] sw_i,
  input  logic       spi_active_i,
  input  logic [7:0] spi_rx_byte_i
);

  logic [7:0] scratch0_q, scratch0_d;
  logic [7:0] scratch1_q, scratch1_d;
  logic [7:0] led_q, led_d;

  // Next-state for writable registers; RO and unmapped addresses drop the write
  always_comb begin
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    led_d      = led_q;
    if (wr_i) begin
      case (addr_i)
        AddrScratch0: scratch0_d = wdata_i;
        AddrScratch1: scratch1_d = wdata_i;
        AddrLedOut:   led_d      = wdata_i;
        default: ;
      endcase
    end
  end

  // Register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch0_q <= 8'h00;
      scratch1_q <= 8'h00;
      led_q      <= 8'h00;
    end else begin
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      led_q      <= led_d;
    end
  end

  // Read mux; output is zero unless the FSM is actually loading a byte
  always_comb begin
    rdata_o = 8'h00;
    if (rd_i) begin
      case (addr_i)
        AddrDeviceId:   rdata_o = DeviceId;
        AddrVersionMaj: rdata_o = VersionMaj;
        AddrVersionMin: rdata_o = VersionMin;
        AddrScratch0:   rdata_o = scratch0_q;
        AddrScratch1:   rdata_o = scratch1_q;
        AddrLinkCaps:   rdata_o = LinkCaps;
        AddrLinkStatus: rdata_o = {7'b0, spi_active_i};
        AddrSpiRx:      rdata_o = spi_rx_byte_i;
        AddrLedOut:     rdata_o = led_q;
        AddrSwIn:       rdata_o = sw_i;
        default:        rdata_o = 8'h00;
      endcase
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target front end: synchronizes SCL/SDA, decodes START/STOP and bytes,
// drives ACK/read data open-drain style and talks to the register map.
module i2c_slave_regs
  import i2c_slave_regs_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe,
  output logic [7:0] led_out,
  input  logic [7:0] sw_in,
  input  logic       spi_active,
  input  logic [7:0] spi_rx_byte
);

  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_prev_q, sda_prev_q;
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;   // bit 7 never needs storing: it is on the wire
  logic [7:0] ptr_q, ptr_d;
  logic       first_q, first_d;   // next write byte is the register pointer
  logic       rw_q, rw_d;
  logic       phase_q, phase_d;   // second half of an ACK bit
  logic       sda_o_q, sda_o_d, sda_oe_q, sda_oe_d;

  logic       scl, sda, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in, reg_rdata;
  logic       reg_wr, reg_rd;

  // Two-stage synchronizer next-state
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
  end

  assign scl       = scl_sync_q[1];
  assign sda       = sda_sync_q[1];
  assign scl_rise  = scl & ~scl_prev_q;
  assign scl_fall  = ~scl & scl_prev_q;
  assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;
  assign byte_in   = {shift_q, sda};

  // Protocol FSM next-state; START/STOP take priority over any bit activity
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    first_d   = first_q;
    rw_d      = rw_q;
    phase_d   = phase_q;
    sda_o_d   = sda_o_q;
    sda_oe_d  = sda_oe_q;
    reg_wr    = 1'b0;
    reg_rd    = 1'b0;
    if (start_det || stop_det) begin
      state_d   = start_det ? StAddr : StIdle;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      sda_o_d   = 1'b1;
    end else begin
      unique case (state_q)
        StAddr: if (scl_rise) begin
          shift_d   = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            phase_d = 1'b0;
            rw_d    = sda;
            state_d = (byte_in[7:1] == SLAVE_ADDR) ? StAckAddr : StWaitStop;
          end
        end
        StAckAddr, StAckWr, StRdAck: begin
          if (state_q == StRdAck && scl_rise && !phase_q) begin
            // Master ACK (low) continues the burst, NACK ends it
            if (sda) begin
              state_d = StWaitStop;
            end else begin
              phase_d = 1'b1;
              ptr_d   = ptr_q + 8'd1;
            end
          end else if (scl_fall && state_q != StRdAck && !phase_q) begin
            phase_d  = 1'b1;
            sda_oe_d = 1'b1;
            sda_o_d  = 1'b0;
          end else if (scl_fall && phase_q) begin
            bit_cnt_d = 3'd0;
            if (state_q == StRdAck || rw_q) begin
              // Falling edge that ends the ACK: load and present the next MSB
              reg_rd   = 1'b1;
              shift_d  = reg_rdata[6:0];
              sda_o_d  = reg_rdata[7];
              sda_oe_d = 1'b1;
              state_d  = StRdByte;
            end else begin
              sda_oe_d = 1'b0;
              sda_o_d  = 1'b1;
              first_d  = (state_q == StAckAddr);
              state_d  = StWrByte;
            end
          end
        end
        StWrByte: if (scl_rise) begin
          shift_d   = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            phase_d = 1'b0;
            state_d = StAckWr;
            if (first_q) begin
              ptr_d   = byte_in;
              first_d = 1'b0;
            end else begin
              reg_wr = 1'b1;
              ptr_d  = ptr_q + 8'd1;
            end
          end
        end
        StRdByte: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            sda_o_d  = 1'b1;
            phase_d  = 1'b0;
            state_d  = StRdAck;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            sda_o_d   = shift_q[6];
            shift_d   = {shift_q[5:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Synchronizer, edge history and FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      ptr_q      <= 8'h00;
      first_q    <= 1'b0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      sda_o_q    <= 1'b1;
      sda_oe_q   <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl;
      sda_prev_q <= sda;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      first_q    <= first_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      sda_o_q    <= sda_o_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  assign sda_o  = sda_o_q;
  assign sda_oe = sda_oe_q;

  i2c_reg_map u_reg_map (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr_i        (ptr_q),
    .wdata_i       (byte_in),
    .wr_i          (reg_wr),
    .rd_i          (reg_rd),
    .rdata_o       (reg_rdata),
    .led_o         (led_out),
    .sw_i          (sw_in),
    .spi_active_i  (spi_active),
    .spi_rx_byte_i (spi_rx_byte)
  );

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bit-banged I2C master plus a register-level
// model of the device's map and pointer.
module tb_i2c_slave_regs;

  localparam logic [6:0] Sa = 7'h50;
  localparam int Q = 60;  // quarter SCL period (clk period is 10)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m, sda_bus;
  logic       sda_o, sda_oe, spi_active;
  logic [7:0] led_out, sw_in, spi_rx_byte;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] m_scr0, m_scr1, m_led, m_ptr;
  logic [7:0] xbuf [16];
  logic [7:0] rbuf [16];

  always #5 clk = ~clk;
  assign sda_bus = sda_m & ~(sda_oe & ~sda_o);

  i2c_slave_regs dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
    .sda_o       (sda_o),
    .sda_oe      (sda_oe),
    .led_out     (led_out),
    .sw_in       (sw_in),
    .spi_active  (spi_active),
    .spi_rx_byte (spi_rx_byte)
  );

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return 8'hA7;
      8'h01:   return 8'h01;
      8'h02:   return 8'h00;
      8'h05:   return m_scr0;
      8'h06:   return m_scr1;
      8'h10:   return 8'h95;
      8'h11:   return {7'b0, spi_active};
      8'h12:   return spi_rx_byte;
      8'h20:   return m_led;
      8'h22:   return sw_in;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h05) m_scr0 = d;
    else if (a == 8'h06) m_scr1 = d;
    else if (a == 8'h20) m_led = d;
  endtask

  task automatic model_reset();
    m_scr0 = 8'h00; m_scr1 = 8'h00; m_led = 8'h00; m_ptr = 8'h00;
  endtask

  // ---------------- bus primitives ----------------
  task automatic bus_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_m = b[7-i]; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    end
  endtask

  task automatic get_ack(output bit acked);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
    acked = (sda_bus == 1'b0);
    #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output bit acked);
    send_bits(b, 8);
    get_ack(acked);
  endtask

  task automatic read_byte(input bit mack, output logic [7:0] b, output bit oe_ok);
    b = 8'h00; oe_ok = 1'b1; sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #Q; scl_m = 1'b1; #Q;
      b = {b[6:0], sda_bus};
      if (sda_oe !== 1'b1) oe_ok = 1'b0;
      #Q; scl_m = 1'b0;
    end
    #20; sda_m = ~mack; #(Q-20); scl_m = 1'b1; #Q;
    if (sda_oe !== 1'b0) oe_ok = 1'b0;
    #Q; scl_m = 1'b0; #Q;
  endtask

  // ---------------- transactions (model bookkeeping only) ----------------
  task automatic do_write(input logic [7:0] a, input int n, output bit ok);
    bit ack;
    ok = 1'b1;
    bus_start();
    write_byte({Sa, 1'b0}, ack); ok = ok & ack;
    write_byte(a, ack); ok = ok & ack;
    m_ptr = a;
    for (int i = 0; i < n; i++) begin
      write_byte(xbuf[i], ack); ok = ok & ack;
      model_write(m_ptr, xbuf[i]);
      m_ptr = m_ptr + 8'd1;
    end
    bus_stop();
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] a, input int n, output bit ok);
    bit ack, oe_ok;
    logic [7:0] b;
    ok = 1'b1;
    if (set_ptr) begin
      bus_start();
      write_byte({Sa, 1'b0}, ack); ok = ok & ack;
      write_byte(a, ack); ok = ok & ack;
      m_ptr = a;
    end
    bus_start();
    write_byte({Sa, 1'b1}, ack); ok = ok & ack;
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, b, oe_ok);
      rbuf[i] = b;
      ok = ok & oe_ok;
      if (i != n - 1) m_ptr = m_ptr + 8'd1;
    end
    bus_stop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    sw_in = 8'h00; spi_active = 1'b0; spi_rx_byte = 8'h00;
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sda_oe !== 1'b0) begin n_errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    n_checks++;
    if (sda_o !== 1'b1) begin n_errors++; $display("FAIL reset_sda_o: got %b expected 1", sda_o); end
    n_checks++;
    if (led_out !== 8'h00) begin n_errors++; $display("FAIL reset_led: got %02h expected 00", led_out); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_id_regs();
    bit ok;
    logic [7:0] exp [3];
    exp[0] = 8'hA7; exp[1] = 8'h01; exp[2] = 8'h00;
    do_read(1'b1, 8'h00, 3, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_errors++; $display("FAIL id_handshake: got %b expected 1", ok); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rbuf[i] !== exp[i]) begin
        n_errors++; $display("FAIL id_byte%0d: got %02h expected %02h", i, rbuf[i], exp[i]);
      end
    end
  endtask

  task automatic test_scratch();
    bit ok, rok;
    logic [7:0] vals [3];
    logic [7:0] addrs [3];
    vals[0] = 8'h55; vals[1] = 8'hAA; vals[2] = 8'h12;
    addrs[0] = 8'h05; addrs[1] = 8'h05; addrs[2] = 8'h06;
    for (int i = 0; i < 3; i++) begin
      xbuf[0] = vals[i];
      do_write(addrs[i], 1, ok);
      do_read(1'b1, addrs[i], 1, rok);
      n_checks++;
      if ((ok & rok) !== 1'b1) begin n_errors++; $display("FAIL scratch_ack%0d: got 0 expected 1", i); end
      n_checks++;
      if (rbuf[0] !== vals[i]) begin
        n_errors++; $display("FAIL scratch_rd%0d: got %02h expected %02h", i, rbuf[0], vals[i]);
      end
    end
  endtask

  task automatic test_link();
    bit ok;
    logic [7:0] exp;
    spi_active = 1'($urandom_range(0, 1));
    spi_rx_byte = 8'($urandom);
    do_read(1'b1, 8'h10, 3, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_errors++; $display("FAIL link_handshake: got %b expected 1", ok); end
    for (int i = 0; i < 3; i++) begin
      exp = model_read(8'h10 + 8'(i));
      n_checks++;
      if (rbuf[i] !== exp) begin
        n_errors++; $display("FAIL link_byte%0d: got %02h expected %02h", i, rbuf[i], exp);
      end
    end
  endtask

  task automatic test_led();
    bit a1, a2, a3, rok;
    bus_start();
    write_byte({Sa, 1'b0}, a1);
    write_byte(8'h20, a2);
    m_ptr = 8'h20;
    send_bits(8'hF0, 7);
    sda_m = 1'b0; #Q; scl_m = 1'b1; #60;
    n_checks++;
    if (led_out !== 8'hF0) begin n_errors++; $display("FAIL led_latency: got %02h expected f0", led_out); end
    #(2*Q-60); scl_m = 1'b0; #Q;
    get_ack(a3);
    model_write(8'h20, 8'hF0);
    m_ptr = m_ptr + 8'd1;
    bus_stop();
    do_read(1'b1, 8'h20, 1, rok);
    n_checks++;
    if ((a1 & a2 & a3 & rok) !== 1'b1) begin n_errors++; $display("FAIL led_ack: got 0 expected 1"); end
    n_checks++;
    if (rbuf[0] !== m_led) begin n_errors++; $display("FAIL led_readback: got %02h expected %02h", rbuf[0], m_led); end
  endtask

  task automatic test_switch();
    bit ok;
    logic [7:0] sws [2];
    sws[0] = 8'h3C; sws[1] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      sw_in = sws[i];
      do_read(1'b1, 8'h22, 1, ok);
      n_checks++;
      if (ok !== 1'b1 || rbuf[0] !== sws[i]) begin
        n_errors++; $display("FAIL switch%0d: got %02h ok=%b expected %02h", i, rbuf[0], ok, sws[i]);
      end
    end
  endtask

  task automatic test_bad_addr();
    bit ack, ok;
    bus_start();
    write_byte({7'h51, 1'b0}, ack);
    bus_stop();
    n_checks++;
    if (ack !== 1'b0) begin n_errors++; $display("FAIL bad_addr_nack: got ack=%b expected 0", ack); end
    do_read(1'b1, 8'h05, 1, ok);
    n_checks++;
    if (ok !== 1'b1 || rbuf[0] !== m_scr0) begin
      n_errors++; $display("FAIL after_bad_addr: got %02h ok=%b expected %02h", rbuf[0], ok, m_scr0);
    end
  endtask

  task automatic test_abort();
    bit a1, a2, a3, oe_ok, ok;
    logic [7:0] b;
    // STOP in the middle of a data byte must not write
    bus_start();
    write_byte({Sa, 1'b0}, a1);
    write_byte(8'h05, a2);
    m_ptr = 8'h05;
    send_bits(~m_scr0, 4);
    bus_stop();
    do_read(1'b1, 8'h05, 1, ok);
    n_checks++;
    if ((a1 & a2 & ok) !== 1'b1 || rbuf[0] !== m_scr0) begin
      n_errors++; $display("FAIL stop_abort: got %02h expected %02h", rbuf[0], m_scr0);
    end
    // Repeated START mid-byte restarts address decode
    bus_start();
    write_byte({Sa, 1'b0}, a1);
    write_byte(8'h06, a2);
    m_ptr = 8'h06;
    send_bits(~m_scr1, 3);
    bus_start();
    write_byte({Sa, 1'b1}, a3);
    read_byte(1'b0, b, oe_ok);
    bus_stop();
    n_checks++;
    if ((a1 & a2 & a3 & oe_ok) !== 1'b1 || b !== m_scr1) begin
      n_errors++; $display("FAIL start_abort: got %02h expected %02h", b, m_scr1);
    end
  endtask

  task automatic test_wrap();
    bit ok, rok;
    logic [7:0] exp;
    for (int i = 0; i < 3; i++) xbuf[i] = 8'($urandom);
    do_write(8'hFE, 3, ok);  // FE, FF, 00 are all ignored; pointer lands on 01
    do_read(1'b0, 8'h00, 1, rok);
    n_checks++;
    if ((ok & rok) !== 1'b1 || rbuf[0] !== 8'h01) begin
      n_errors++; $display("FAIL wrap_write: got %02h expected 01", rbuf[0]);
    end
    do_read(1'b1, 8'hFF, 2, rok);
    for (int i = 0; i < 2; i++) begin
      exp = (i == 0) ? 8'h00 : 8'hA7;
      n_checks++;
      if (rok !== 1'b1 || rbuf[i] !== exp) begin
        n_errors++; $display("FAIL wrap_read%0d: got %02h expected %02h", i, rbuf[i], exp);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    logic [7:0] a, exp;
    logic [7:0] pool [8];
    pool[0] = 8'h05; pool[1] = 8'h06; pool[2] = 8'h20; pool[3] = 8'h00;
    pool[4] = 8'h10; pool[5] = 8'h22; pool[6] = 8'h33; pool[7] = 8'h11;
    for (int it = 0; it < 14; it++) begin
      a = pool[$urandom_range(0, 7)];
      n = $urandom_range(1, 3);
      sw_in = 8'($urandom);
      spi_active = 1'($urandom_range(0, 1));
      spi_rx_byte = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) xbuf[i] = 8'($urandom);
        do_write(a, n, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_errors++; $display("FAIL rnd_write%0d: got nack expected ack", it); end
        n_checks++;
        if (led_out !== m_led) begin
          n_errors++; $display("FAIL rnd_led%0d: got %02h expected %02h", it, led_out, m_led);
        end
      end else begin
        do_read(1'b1, a, n, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_errors++; $display("FAIL rnd_rd_handshake%0d: got 0 expected 1", it); end
        for (int i = 0; i < n; i++) begin
          exp = model_read(a + 8'(i));
          n_checks++;
          if (rbuf[i] !== exp) begin
            n_errors++;
            $display("FAIL rnd_read%0d_%0d: got %02h expected %02h", it, i, rbuf[i], exp);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, rok;
    xbuf[0] = 8'h5A;
    do_write(8'h20, 1, ok);
    bus_start();
    send_bits({Sa, 1'b0}, 8);
    sda_m = 1'b1; #Q;  // target is now driving the address ACK
    n_checks++;
    if (sda_oe !== 1'b1 || sda_o !== 1'b0) begin
      n_errors++; $display("FAIL mid_ack_drive: got oe=%b o=%b expected oe=1 o=0", sda_oe, sda_o);
    end
    rst_n = 1'b0; #1;
    n_checks++;
    if (sda_oe !== 1'b0 || sda_o !== 1'b1 || led_out !== 8'h00) begin
      n_errors++;
      $display("FAIL mid_reset: got oe=%b o=%b led=%02h expected oe=0 o=1 led=00", sda_oe, sda_o, led_out);
    end
    model_reset();
    #20; scl_m = 1'b1; #Q; rst_n = 1'b1; #Q;
    do_read(1'b0, 8'h00, 1, rok);
    n_checks++;
    if ((ok & rok) !== 1'b1 || rbuf[0] !== 8'hA7) begin
      n_errors++; $display("FAIL ptr_after_reset: got %02h expected a7", rbuf[0]);
    end
  endtask

  initial begin
    test_reset();
    test_id_regs();
    test_scratch();
    test_link();
    test_led();
    test_switch();
    test_bad_addr();
    test_abort();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
